fp32_mul_stream: RTL and testbench

FP32_MUL_STREAM -- requirements
Module: fp32_mul_stream

---
 rtl/fp32_mul_stream.sv | 141 ++++++++++++++
 tb/tb_fp32_mul_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_stream.sv
// Stream wrapper around a fixed-latency FP32 multiplier core with no back-pressure.
// Credits (inflight + FIFO occupancy) bound outstanding work so no core result is ever dropped.
module fp32_mul_stream #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_a_tdata,
  output logic [31:0] mul_b_tdata,
  output logic        mul_tvalid,
  input  logic [31:0] mul_result_tdata,
  input  logic        mul_result_tvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        err_unexpected,
  output logic        err_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mul_a_q, mul_a_d;
  logic [31:0]   mul_b_q, mul_b_d;
  logic          mul_tvalid_q, mul_tvalid_d;
  logic          in_ready_q, in_ready_d;
  logic          err_unexp_q, err_unexp_d;
  logic          err_ovf_q, err_ovf_d;
  logic [31:0]   mem_q [DEPTH];

  logic          issue_s, res_s, rd_s, wr_s;
  logic [CW:0]   sum_s;

  // Handshake decode, credit counters, FIFO pointers and sticky error flags.
  always_comb begin
    issue_s      = in_valid && in_ready_q;
    res_s        = mul_result_tvalid && (inflight_q != '0);
    rd_s         = (count_q != '0) && out_ready;
    wr_s         = res_s && ((count_q != DEPTH_C) || rd_s);

    inflight_d   = inflight_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_tvalid_d = issue_s;

    case ({issue_s, res_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (issue_s) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
    end else begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
    end

    // in_ready is registered from next-state credits, so it never depends on in_valid/out_ready.
    sum_s       = {1'b0, inflight_d} + {1'b0, count_d};
    in_ready_d  = (sum_s < {1'b0, DEPTH_C});

    err_unexp_d = err_unexp_q | (mul_result_tvalid && (inflight_q == '0));
    err_ovf_d   = err_ovf_q | (res_s && (count_q == DEPTH_C) && !rd_s);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mul_a_q      <= 32'h0000_0000;
      mul_b_q      <= 32'h0000_0000;
      mul_tvalid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      err_unexp_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_tvalid_q <= mul_tvalid_d;
      in_ready_q   <= in_ready_d;
      err_unexp_q  <= err_unexp_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  // Result storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= mul_result_tdata;
    end
  end

  assign in_ready       = in_ready_q;
  assign mul_a_tdata    = mul_a_q;
  assign mul_b_tdata    = mul_b_q;
  assign mul_tvalid     = mul_tvalid_q;
  assign out_valid      = (count_q != '0);
  assign out_data       = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0000_0000;
  assign err_unexpected = err_unexp_q;
  assign err_overflow   = err_ovf_q;

endmodule

// File: tb/tb_fp32_mul_stream.sv
// Bench for fp32_mul_stream: fixed-latency core model, scoreboard queue of expected products.
// Expected products come from an independent FP32 multiply for normal operands.
module tb_fp32_mul_stream;

  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'h0;
  logic [31:0] in_b = 32'h0;
  logic [31:0] mul_a_tdata, mul_b_tdata;
  logic        mul_tvalid;
  logic [31:0] mul_result_tdata;
  logic        mul_result_tvalid;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        err_unexpected, err_overflow;
  logic        inj = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int sidx = 0;
  int ready_drops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] opa[$];
  logic [31:0] opb[$];

  fp32_mul_stream #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a_tdata(mul_a_tdata), .mul_b_tdata(mul_b_tdata), .mul_tvalid(mul_tvalid),
    .mul_result_tdata(mul_result_tdata), .mul_result_tvalid(mul_result_tvalid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_unexpected(err_unexpected), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Round-to-nearest-even FP32 multiply, normal operands and results only.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [23:0] m;
    logic [9:0]  e;
    logic        rnd, sticky;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; rnd = p[23]; sticky = |p[22:0]; e = e + 10'd1;
    end else begin
      m = {1'b0, p[45:23]}; rnd = p[22]; sticky = |p[21:0];
    end
    if (rnd && (sticky || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m = 24'd0; e = e + 10'd1;
    end
    return {a[31] ^ b[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
    s = 1'($urandom_range(1, 0));
    e = 8'($urandom_range(154, 100));
    f = 23'($urandom());
    return {s, e, f};
  endfunction

  // Multiplier core model: LAT-cycle pipeline, reset with the same rst_n.
  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mul_tvalid};
      pd[0] <= fp_mul(mul_a_tdata, mul_b_tdata);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign mul_result_tvalid = pv[LAT-1] | inj;
  assign mul_result_tdata  = pd[LAT-1];

  // Scoreboard: push on accepted operands, pop and compare on delivered products.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(fp_mul(in_a, in_b));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check_eq("sb_unexpected_output", out_data, 32'hxxxx_xxxx);
        else check_eq("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic gen_ops(input int n);
    opa.delete(); opb.delete(); sidx = 0;
    for (int i = 0; i < n; i++) begin
      opa.push_back(rand_fp());
      opb.push_back(rand_fp());
    end
  endtask

  task automatic run_stream(input int n, input int budget, input bit watch_ready);
    int  cyc;
    bit  acc;
    cyc = 0;
    while (sidx < n && cyc < budget) begin
      in_valid = 1'b1; in_a = opa[sidx]; in_b = opb[sidx];
      @(negedge clk);
      acc = in_ready;
      if (watch_ready && sidx > 0 && !in_ready) ready_drops++;
      @(posedge clk); #1;
      cyc++;
      if (acc) sidx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_result(input string tag);
    int c;
    c = 0;
    while (!mul_result_tvalid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq(tag, mul_result_tvalid, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, cyc;

    // Reset values while rst_n is low.
    #12;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_mul_tvalid", mul_tvalid, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_errs", {err_unexpected, err_overflow}, 2'b00);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_in_ready", in_ready, 1'b1);

    // Basic 2.0 * 3.0; latency counted in edges after the accepting edge.
    opa.delete(); opb.delete(); sidx = 0;
    opa.push_back(32'h4000_0000); opb.push_back(32'h4040_0000);
    out_ready = 1'b1;
    base = n_out;
    run_stream(1, 10, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("basic_latency", cyc, LAT + 1);
    check_eq("basic_data", out_data, 32'h40C0_0000);
    repeat (10) @(posedge clk);
    #1;
    check_eq("basic_beats", n_out - base, 1);

    // Backpressure: only DEPTH accepted while the consumer stalls.
    out_ready = 1'b0;
    gen_ops(10);
    base = n_out;
    run_stream(10, 20, 1'b0);
    check_eq("bp_accepted", sidx, DEPTH);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check_eq("bp_ready_low", in_ready, 1'b0);
    check_eq("bp_count_full", dut.count_q, DEPTH);
    check_eq("bp_no_output", n_out - base, 0);
    out_ready = 1'b1;
    run_stream(10, 60, 1'b0);
    check_eq("bp_all_accepted", sidx, 10);
    wait_drain("bp_drain", 60);
    check_eq("bp_beats", n_out - base, 10);
    check_eq("bp_errs", {err_unexpected, err_overflow}, 2'b00);

    // Full rate: 100 back-to-back operations.
    gen_ops(100);
    ready_drops = 0;
    base = n_out;
    run_stream(100, 300, 1'b1);
    check_eq("fr_accepted", sidx, 100);
    check_eq("fr_ready_drops", ready_drops, 0);
    wait_drain("fr_drain", 60);
    check_eq("fr_beats", n_out - base, 100);

    // Issue and result in the same cycle keep inflight constant.
    gen_ops(2);
    run_stream(1, 10, 1'b0);
    wait_result("sim_result_seen");
    check_eq("sim_inflight_pre", dut.inflight_q, 1);
    in_valid = 1'b1; in_a = opa[1]; in_b = opb[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("sim_inflight_post", dut.inflight_q, 1);
    wait_drain("sim_drain1", 30);

    // FIFO at DEPTH-1 with write and read in the same cycle.
    out_ready = 1'b0;
    gen_ops(DEPTH);
    run_stream(DEPTH - 1, 20, 1'b0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check_eq("sim_count_pre", dut.count_q, DEPTH - 1);
    run_stream(DEPTH, 5, 1'b0);
    wait_result("sim_fifo_result_seen");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("sim_count_post", dut.count_q, DEPTH - 1);
    out_ready = 1'b1;
    wait_drain("sim_drain2", 40);

    // Spurious result with nothing outstanding.
    check_eq("spur_inflight_zero", dut.inflight_q, 0);
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    check_eq("spur_err", err_unexpected, 1'b1);
    check_eq("spur_count", dut.count_q, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("spur_sticky", err_unexpected, 1'b1);
    check_eq("spur_no_ovf", err_overflow, 1'b0);

    // Asynchronous reset with four operations in flight.
    out_ready = 1'b0;
    gen_ops(4);
    run_stream(4, 10, 1'b0);
    check_eq("mid_inflight", dut.inflight_q, 4);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("mid_in_ready", in_ready, 1'b0);
    check_eq("mid_mul_tvalid", mul_tvalid, 1'b0);
    check_eq("mid_mul_a", mul_a_tdata, 32'h0);
    check_eq("mid_mul_b", mul_b_tdata, 32'h0);
    check_eq("mid_out_valid", out_valid, 1'b0);
    check_eq("mid_out_data", out_data, 32'h0);
    check_eq("mid_errs", {err_unexpected, err_overflow}, 2'b00);
    check_eq("mid_inflight_clr", dut.inflight_q, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rel_in_ready", in_ready, 1'b1);
    check_eq("mid_rel_out_valid", out_valid, 1'b0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check_eq("mid_no_stale_err", err_unexpected, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
